// File: rtl/vga_display_ctrl.sv
// Display update controller: arbitrates two requesters into a one-entry shadow
// register and commits it to the live digit/instruction outputs at vertical blank.
module vga_display_ctrl #(
    parameter logic [7:0] TIMEOUT_FRAMES = 8'd180,
    parameter logic [3:0] MAX_DIGIT      = 4'd9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vBlank,
    input  logic       req0_valid,
    input  logic [3:0] req0_digit,
    input  logic       req0_clear,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_digit,
    input  logic       req1_clear,
    output logic       req1_ready,
    output logic [3:0] digit,
    output logic       digitEn,
    output logic       instrEn,
    output logic       busy,
    output logic       updErr
);

    typedef enum logic {
        ST_INSTR = 1'b0,
        ST_SHOW  = 1'b1
    } disp_state_t;

    logic        vb_sync1_q, vb_sync2_q, vb_prev_q, frame_tick_q;
    logic        prio_q, prio_d;
    logic        busy_q, busy_d;
    logic        sh_instr_q, sh_instr_d;
    logic [3:0]  sh_digit_q, sh_digit_d;
    logic        upd_err_q, upd_err_d;
    disp_state_t state_q, state_d;
    logic [3:0]  digit_q, digit_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  cnt_inc;

    logic       grant0, grant1, xfer, sel_clear, illegal;
    logic [3:0] sel_digit;

    // Handshake: a transfer happens on a cycle where reqN_valid & reqN_ready.
    // Ready is granted to at most one requester, only while the shadow is empty;
    // prio_q=0 favours req0 and flips away from the winner of every transfer.
    always_comb begin
        grant0    = req0_valid & ~busy_q & (~req1_valid | ~prio_q);
        grant1    = req1_valid & ~busy_q & (~req0_valid |  prio_q);
        xfer      = grant0 | grant1;
        sel_clear = grant1 ? req1_clear : req0_clear;
        sel_digit = grant1 ? req1_digit : req0_digit;
        illegal   = xfer & ~sel_clear & (sel_digit > MAX_DIGIT);
        cnt_inc   = (frame_cnt_q == 8'd255) ? 8'd255 : frame_cnt_q + 8'd1;
    end

    always_comb begin
        prio_d      = prio_q;
        busy_d      = busy_q;
        sh_instr_d  = sh_instr_q;
        sh_digit_d  = sh_digit_q;
        upd_err_d   = illegal;
        state_d     = state_q;
        digit_d     = digit_q;
        frame_cnt_d = frame_cnt_q;

        if (frame_tick_q && busy_q) begin
            busy_d      = 1'b0;
            frame_cnt_d = 8'd0;
            if (sh_instr_q) begin
                state_d = ST_INSTR;
            end else begin
                state_d = ST_SHOW;
                digit_d = sh_digit_q;
            end
        end else if (frame_tick_q && state_q == ST_SHOW) begin
            if (TIMEOUT_FRAMES != 8'd0 && cnt_inc == TIMEOUT_FRAMES) begin
                state_d     = ST_INSTR;
                frame_cnt_d = 8'd0;
            end else begin
                frame_cnt_d = cnt_inc;
            end
        end

        // A transfer only occurs with busy_q=0, so it never collides with a commit.
        if (xfer) begin
            prio_d = grant0;
            if (!illegal) begin
                busy_d     = 1'b1;
                sh_instr_d = sel_clear;
                sh_digit_d = sel_digit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vb_sync1_q   <= 1'b0;
            vb_sync2_q   <= 1'b0;
            vb_prev_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            prio_q       <= 1'b0;
            busy_q       <= 1'b0;
            sh_instr_q   <= 1'b0;
            sh_digit_q   <= 4'd0;
            upd_err_q    <= 1'b0;
            state_q      <= ST_INSTR;
            digit_q      <= 4'd0;
            frame_cnt_q  <= 8'd0;
        end else begin
            vb_sync1_q   <= vBlank;
            vb_sync2_q   <= vb_sync1_q;
            vb_prev_q    <= vb_sync2_q;
            frame_tick_q <= vb_sync2_q & ~vb_prev_q;
            prio_q       <= prio_d;
            busy_q       <= busy_d;
            sh_instr_q   <= sh_instr_d;
            sh_digit_q   <= sh_digit_d;
            upd_err_q    <= upd_err_d;
            state_q      <= state_d;
            digit_q      <= digit_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign digit      = digit_q;
    assign digitEn    = (state_q == ST_SHOW);
    assign instrEn    = (state_q == ST_INSTR);
    assign busy       = busy_q;
    assign updErr     = upd_err_q;

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Randomized bench for vga_display_ctrl with a frame-level reference model
// (pending-update queue, display mode, idle-frame count).
module tb_vga_display_ctrl;
    localparam int TO = 3;

    logic       clk = 1'b0;
    logic       reset, vBlank;
    logic       r0v, r0c, r1v, r1c;
    logic [3:0] r0d, r1d;
    logic       r0rdy, r1rdy, digitEn, instrEn, busy, updErr;
    logic [3:0] digit;

    vga_display_ctrl #(.TIMEOUT_FRAMES(8'd3), .MAX_DIGIT(4'd9)) dut (
        .clk(clk), .reset(reset), .vBlank(vBlank),
        .req0_valid(r0v), .req0_digit(r0d), .req0_clear(r0c), .req0_ready(r0rdy),
        .req1_valid(r1v), .req1_digit(r1d), .req1_clear(r1c), .req1_ready(r1rdy),
        .digit(digit), .digitEn(digitEn), .instrEn(instrEn), .busy(busy), .updErr(updErr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: vBlank history (rise seen 3 edges ago commits now),
    // pending updates as a queue {instr, digit}, live display mode.
    logic [3:0] vh = 4'd0;
    logic [4:0] pend_q[$];
    bit         m_show = 1'b0;
    logic [3:0] m_digit = 4'd0;
    int         m_idle = 0;
    bit         m_err = 1'b0;
    int         last_g = 1;
    int         g_cyc = -1;

    // Frame generator
    int  fp_len = 30;
    int  fp_pos = 0;
    bit  rand_frames = 1'b0;

    function automatic int grant_of();
        if (pend_q.size() != 0) return -1;
        if (r0v && r1v) return (last_g == 0) ? 1 : 0;
        if (r0v) return 0;
        if (r1v) return 1;
        return -1;
    endfunction

    task automatic model_edge(input int g);
        bit         tick, ill, c;
        logic [3:0] d;
        logic [4:0] e;
        if (reset) begin
            vh = 4'd0; pend_q.delete(); m_show = 0; m_digit = 0;
            m_idle = 0; m_err = 0; last_g = 1;
        end else begin
            tick = vh[2] && !vh[3];
            ill  = 1'b0;
            if (tick && pend_q.size() != 0) begin
                e = pend_q.pop_front();
                if (e[4]) m_show = 0;
                else begin m_show = 1; m_digit = e[3:0]; end
                m_idle = 0;
            end else if (tick && m_show) begin
                m_idle = (m_idle < 255) ? m_idle + 1 : 255;
                if (TO != 0 && m_idle == TO) begin m_show = 0; m_idle = 0; end
            end
            if (g >= 0) begin
                c = (g == 1) ? r1c : r0c;
                d = (g == 1) ? r1d : r0d;
                if (c) pend_q.push_back({1'b1, 4'd0});
                else if (d <= 4'd9) pend_q.push_back({1'b0, d});
                else ill = 1'b1;
                last_g = g;
            end
            m_err = ill;
            vh = {vh[2:0], vBlank};
        end
    endtask

    // One clock: called just after a falling edge, returns just after the next one.
    task automatic cycle();
        int g;
        vBlank = (fp_pos < 5);
        fp_pos++;
        if (fp_pos >= fp_len) begin
            fp_pos = 0;
            if (rand_frames) fp_len = $urandom_range(12, 40);
        end
        #1;
        g = grant_of();
        check("ready0", r0rdy, (g == 0));
        check("ready1", r1rdy, (g == 1));
        check("one_ready", r0rdy & r1rdy, 0);
        @(posedge clk);
        model_edge(g);
        g_cyc = g;
        #1;
        check("digit", digit, m_digit);
        check("digitEn", digitEn, m_show);
        check("instrEn", instrEn, !m_show);
        check("busy", busy, (pend_q.size() != 0));
        check("updErr", updErr, m_err);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Hold valid until accepted
    task automatic send(input int who, input logic [3:0] d, input logic c);
        if (who == 0) begin r0v = 1; r0d = d; r0c = c; end
        else begin r1v = 1; r1d = d; r1c = c; end
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (g_cyc == who) break;
        end
        check("send_accepted", g_cyc, who);
        if (who == 0) r0v = 0; else r1v = 0;
    endtask

    initial begin
        reset = 1; vBlank = 0;
        r0v = 0; r0d = 0; r0c = 0; r1v = 0; r1d = 0; r1c = 0;
        @(negedge clk);
        run(3);
        check("rst_instrEn", instrEn, 1);
        check("rst_digitEn", digitEn, 0);
        reset = 0;

        // Idle frames
        run(5 * 30);
        check("idle_instrEn", instrEn, 1);

        // Single digit from req0
        send(0, 4'd7, 1'b0);
        check("busy_after_accept", busy, 1);
        run(60);
        check("digit7", digit, 7);

        // Both requesters contending for 4 frames
        r0v = 1; r0d = 4'd3; r0c = 0; r1v = 1; r1d = 4'd5; r1c = 0;
        run(4 * 30);
        r0v = 0; r1v = 0;
        run(40);

        // Illegal digit from req1, then legal req0
        send(1, 4'd12, 1'b0);
        cycle();
        send(0, 4'd8, 1'b0);
        run(40);

        // Timeout after 3 idle frames
        send(0, 4'd4, 1'b0);
        run(5 * 30);
        check("timeout_instrEn", instrEn, 1);
        check("timeout_digit", digit, 4);

        // Transfer in the same cycle as a commit tick
        for (int i = 0; i < 100; i++) begin
            if (vh[2] && !vh[3]) break;
            cycle();
        end
        r0v = 1; r0d = 4'd6; r0c = 0;
        cycle();
        r0v = 0;
        check("aligned_busy", busy, 1);
        run(70);

        // Clear request, then reset while an update is pending
        send(1, 4'd0, 1'b1);
        run(40);
        send(0, 4'd2, 1'b0);
        reset = 1;
        cycle();
        reset = 0;
        check("rst_busy_cleared", busy, 0);
        run(3 * 30);
        check("rst_nothing_committed", instrEn, 1);

        // Random traffic
        rand_frames = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if (!r0v && $urandom_range(0, 3) == 0) begin
                r0v = 1; r0d = 4'($urandom_range(0, 15)); r0c = ($urandom_range(0, 7) == 0);
            end
            if (!r1v && $urandom_range(0, 3) == 0) begin
                r1v = 1; r1d = 4'($urandom_range(0, 15)); r1c = ($urandom_range(0, 7) == 0);
            end
            reset = ($urandom_range(0, 499) == 0);
            cycle();
            if (g_cyc == 0) r0v = 0;
            if (g_cyc == 1) r1v = 0;
        end
        reset = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
